// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU types and constants for the fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int unsigned XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    // Fetch front-end control state
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    // One buffered instruction together with the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered writes, combinational head,
//               synchronous active-low clear and a synchronous flush input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam int unsigned    CW       = AW + 1;
    localparam logic [CW-1:0]  C_DEPTH  = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Overflow/underflow requests are silently ignored
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Pointer and occupancy bookkeeping; flush behaves like a clear
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push && rst_n && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == C_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch front end. Owns the fetch PC, issues in-order
//               requests to a variable-latency instruction memory, buffers the
//               returned words and hands {pc, instr, pc+4} to decode. Redirects
//               discard buffered entries and drop stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int unsigned     XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic            busy
);

    import cpu_pkg::*;

    // The buffered entry type carries a cpu_pkg::XLEN-wide pc, so XLEN is
    // expected to stay at its package default.
    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam int unsigned   EW      = $bits(fetch_entry_t);
    localparam logic [CW:0]   C_LIMIT = (CW+1)'(DEPTH);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_stale;

    logic [CW-1:0]   w_ififo_count;
    logic            w_ififo_full;
    logic            w_ififo_empty;
    logic [CW-1:0]   w_pfifo_count;
    logic            w_pfifo_full;
    logic            w_pfifo_empty;
    logic [XLEN-1:0] w_pfifo_head;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    logic            w_credit;
    logic            w_req_fire;
    logic            w_rsp_stale;
    logic            w_rsp_live;
    logic            w_out_fire;
    logic [CW-1:0]   w_stale_dec;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_stale_nxt;
    logic            w_unused;

    // A slot is reserved per outstanding request so a response always fits
    assign w_credit       = ({1'b0, w_ififo_count} + {1'b0, r_outstanding}) < C_LIMIT;
    assign imem_req_valid = reset && (r_state == FETCH) && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses first retire stale requests, then belong to live ones
    assign w_rsp_stale = imem_rsp_valid && (r_stale != '0);
    assign w_rsp_live  = imem_rsp_valid && (r_stale == '0);

    assign w_stale_dec = r_stale - CW'(w_rsp_stale);
    assign w_out_nxt   = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_live);
    // On redirect every live request (including one accepted now) turns stale
    assign w_stale_nxt = redirect_valid ? (w_stale_dec + w_out_nxt) : w_stale_dec;

    assign w_out_fire  = out_valid && out_ready;

    // Address of each accepted request, consumed when its response returns
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_req_fire),
        .i_data  (r_fetch_pc),
        .i_pop   (w_rsp_live),
        .o_data  (w_pfifo_head),
        .o_full  (w_pfifo_full),
        .o_empty (w_pfifo_empty),
        .o_count (w_pfifo_count)
    );

    assign w_push_entry = '{pc: w_pfifo_head, instr: imem_rsp_data};

    // Returned instructions waiting for decode
    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_rsp_live),
        .i_data  (w_push_entry),
        .i_pop   (w_out_fire),
        .o_data  (w_head),
        .o_full  (w_ififo_full),
        .o_empty (w_ififo_empty),
        .o_count (w_ififo_count)
    );

    // Fetch PC, request accounting and FETCH/FLUSH control
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
            r_state       <= FETCH;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_outstanding <= redirect_valid ? '0 : w_out_nxt;
            r_stale       <= w_stale_nxt;
            r_state       <= (w_stale_nxt != '0) ? FLUSH : FETCH;
        end
    end

    assign out_valid    = reset && !w_ififo_empty;
    assign out_pc       = out_valid ? w_head.pc : '0;
    assign out_instr    = out_valid ? w_head.instr : '0;
    assign out_pc_plus4 = out_valid ? (w_head.pc + XLEN'(4)) : '0;
    assign busy         = reset && ((r_outstanding != '0) || (r_state == FLUSH));

    // Status outputs of the FIFOs that the credit scheme makes redundant
    assign w_unused = ^{w_pfifo_full, w_pfifo_empty, w_pfifo_count, w_ififo_full};

endmodule
`default_nettype wire
